// File: rtl/regfile_sb.sv
// Architectural register file with a busy-bit scoreboard.
// Multi-ported combinational reads, multi-ported writeback, and optional
// same-cycle forwarding. x0 is hardwired to zero and is never busy.
// Writeback clears a register's busy flag, allocation sets it (set wins on
// a same-cycle collision), and flush clears every flag. The number of busy
// registers is kept in a register so that it reflects the state after each edge.
module regfile_sb #(
  parameter int XLEN         = 64,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2,
  parameter int BYPASS       = 1,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr_i,
  output logic [NUM_RD_PORTS*XLEN-1:0] rd_data_o,
  output logic [NUM_RD_PORTS-1:0]      rd_busy_o,
  input  logic [NUM_WR_PORTS-1:0]      wr_en_i,
  input  logic [NUM_WR_PORTS*AW-1:0]   wr_addr_i,
  input  logic [NUM_WR_PORTS*XLEN-1:0] wr_data_i,
  input  logic                         alloc_en_i,
  input  logic [AW-1:0]                alloc_addr_i,
  output logic                         alloc_ready_o,
  input  logic                         flush_i,
  output logic [AW:0]                  busy_count_o
);

  logic [XLEN-1:0]     regData_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [AW:0]         busyCount_q;
  logic [AW:0]         busyCount_d;
  logic                allocAccept;

  // An allocation is only acceptable outside a flush, and only to x0 or to a free register
  always_comb begin
    alloc_ready_o = !flush_i && ((alloc_addr_i == '0) || !busy_q[alloc_addr_i]);
    allocAccept   = alloc_en_i && alloc_ready_o;
  end

  // Next busy vector: writebacks clear, flush clears all, an accepted allocation sets last
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
        busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
      end
    end
    if (flush_i) begin
      busy_d = '0;
    end
    if (allocAccept) begin
      busy_d[alloc_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector, registered alongside the flags
  always_comb begin
    busyCount_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busyCount_d = busyCount_d + (AW+1)'(busy_d[i]);
    end
  end

  // Read ports: stored value, optionally overridden by the winning same-cycle write
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_data_o[p*XLEN +: XLEN] = regData_q[rd_addr_i[p*AW +: AW]];
      rd_busy_o[p]              = busy_q[rd_addr_i[p*AW +: AW]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0) &&
              (wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
            rd_data_o[p*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
            rd_busy_o[p]              = 1'b0;
          end
        end
      end
      if (rd_addr_i[p*AW +: AW] == '0) begin
        rd_data_o[p*XLEN +: XLEN] = '0;
        rd_busy_o[p]              = 1'b0;
      end
    end
  end

  // Register storage; ports are scanned in ascending order so the highest index wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regData_q[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
          regData_q[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Busy flags and their count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      busyCount_q <= '0;
    end else begin
      busy_q      <= busy_d;
      busyCount_q <= busyCount_d;
    end
  end

  assign busy_count_o = busyCount_q;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width of each architectural register.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count including x0, power of two; AW = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD_PORTS, default 2, number of independent read ports.
REQ-004 SHALL have parameter NUM_WR_PORTS, default 2, number of writeback ports.
REQ-005 SHALL have parameter BYPASS, default 1, enables same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port rd_addr_i  input  NUM_RD_PORTS*AW  packed read addresses, port p in bits [p*AW +: AW].
REQ-009 SHALL have port rd_data_o  output  NUM_RD_PORTS*XLEN  packed read data.
REQ-010 SHALL have port rd_busy_o  output  NUM_RD_PORTS  busy (pending-write) flag of each addressed register.
REQ-011 SHALL have port wr_en_i  input  NUM_WR_PORTS  per-port writeback enable.
REQ-012 SHALL have port wr_addr_i  input  NUM_WR_PORTS*AW  packed writeback addresses.
REQ-013 SHALL have port wr_data_i  input  NUM_WR_PORTS*XLEN  packed writeback data.
REQ-014 SHALL have port alloc_en_i  input  1  request to mark a destination register busy.
REQ-015 SHALL have port alloc_addr_i  input  AW  destination register to allocate.
REQ-016 SHALL have port alloc_ready_o  output  1  allocation acceptable this cycle.
REQ-017 SHALL have port flush_i  input  1  clear all busy flags (pipeline flush).
REQ-018 SHALL have port busy_count_o  output  AW+1  registered number of busy registers.

Function
REQ-019 x0 SHALL always read 0, ignore writes, never become busy, and never be counted.
REQ-020 Reads SHALL be combinational; port p returns register rd_addr_i[p] (0 for x0).
REQ-021 Writes SHALL update storage at the rising edge when wr_en_i[w] is high and wr_addr_i[w] != 0.
REQ-022 Multiple write ports targeting the same register in one cycle: highest-index port SHALL win.
REQ-023 BYPASS=1: a read matching an enabled nonzero write address SHALL return the winning wr_data_i that same cycle; BYPASS=0: stored value (write visible next cycle).
REQ-024 Enabled writeback to register r SHALL clear busy[r] at the next edge; writeback to a non-busy register only writes data.
REQ-025 rd_busy_o[p] SHALL equal busy[rd_addr_i[p]]; with BYPASS=1 it SHALL be 0 when an enabled write to that address occurs the same cycle.
REQ-026 alloc_ready_o SHALL be combinational: 1 when flush_i=0 and (alloc_addr_i == 0 or busy[alloc_addr_i] == 0); independent of alloc_en_i.
REQ-027 Allocation accepted when alloc_en_i & alloc_ready_o; SHALL set busy[alloc_addr_i] at next edge (no-op for x0); not-accepted requests SHALL change no state.
REQ-028 Accepted allocation and writeback to the same register in one cycle: data SHALL be written and busy SHALL end set (set wins).
REQ-029 flush_i=1 SHALL clear every busy flag at the next edge; register data unaffected; writes in that cycle still complete.
REQ-030 busy_count_o SHALL equal the population count of busy flags after each edge (registered, max NUM_REGS-1, never wraps).

Reset
REQ-031 reset high SHALL immediately clear all registers to 0, all busy flags to 0, busy_count_o to 0, independent of clk.
REQ-032 While reset high, writes, allocations and flushes SHALL be ignored; operation resumes at first edge after deassertion.

Verification
REQ-033 Reset, then read all ports at x1..x31 -> rd_data_o all 0, rd_busy_o 0, busy_count_o 0, alloc_ready_o 1.
REQ-034 wr port0 x5=0xAAAA and port1 x5=0x5555 same cycle, read x5 -> same cycle 0x5555 (BYPASS=1), next cycle stored 0x5555.
REQ-035 alloc x7 -> busy_count_o 1, rd_busy_o 1 at x7; alloc x7 again -> alloc_ready_o 0, count stays 1; writeback x7=0x12 -> busy 0, count 0.
REQ-036 Write x0=0xFFFF and alloc x0 -> x0 reads 0, count 0, alloc_ready_o 1.
REQ-037 Alloc x1,x2,x3, then flush_i with alloc x4 -> alloc_ready_o 0, all busy 0, count 0.
REQ-038 Assert reset mid-cycle after writing x9=0x33 and allocating x9 -> x9 reads 0 and busy_count_o 0 before next clk edge.
